// File: rtl/pr_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the device block.
//   m0_*/m1_* : request side of each master (req/we/addr/wdata in, ack/rdata out)
//   dev_*     : single shared device bus (we/addr/wdata out, rdata in)
//   err       : out-of-range completion pulse
// slave  : arbiter view
// master : environment view (both masters plus the device block)
interface pr_bus_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        err;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  dev_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output dev_we, dev_addr, dev_wdata, err
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output dev_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  dev_we, dev_addr, dev_wdata, err
    );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter for the processor device bus.
// One transaction in flight at a time; each takes WAIT_CYCLES+1 XFER cycles
// followed by a one-cycle ack (and err for addresses above ADDR_MAX).
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : pr_bus_arbiter_if.slave (master requests, device bus, err)
module pr_bus_arbiter #(
    parameter int          WAIT_CYCLES = 0,            // 0..15
    parameter logic [31:0] ADDR_MAX    = 32'h0000_7FFF
) (
    input  logic           clk,
    input  logic           rst,
    pr_bus_arbiter_if.slave bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t      state;
    logic        ptr;        // 0: m0 wins a tie, 1: m1 wins a tie
    logic        win;        // master owning the current transaction
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  cnt;
    logic        ack0, ack1, err_q;
    logic [31:0] rd0, rd1;

    // A master sitting in its ack cycle still shows req; ignore it so the
    // same request is not granted twice.
    logic elig0, elig1, pick1, in_range, last;

    assign elig0    = bus.m0_req & ~ack0;
    assign elig1    = bus.m1_req & ~ack1;
    assign pick1    = elig1 & (~elig0 | ptr);
    assign in_range = (l_addr <= ADDR_MAX);
    assign last     = (state == XFER) && (cnt == 4'd0);

    // The latched address/data double as the device bus, so they naturally
    // hold their last values outside XFER.
    assign bus.dev_addr  = l_addr;
    assign bus.dev_wdata = l_wdata;
    assign bus.dev_we    = last & l_we & in_range;
    assign bus.m0_ack    = ack0;
    assign bus.m1_ack    = ack1;
    assign bus.m0_rdata  = rd0;
    assign bus.m1_rdata  = rd1;
    assign bus.err       = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            win     <= 1'b0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            cnt     <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err_q   <= 1'b0;
            rd0     <= '0;
            rd1     <= '0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            err_q <= 1'b0;
            if (state == IDLE) begin
                if (elig0 | elig1) begin
                    win     <= pick1;
                    ptr     <= ~pick1;
                    l_we    <= pick1 ? bus.m1_we    : bus.m0_we;
                    l_addr  <= pick1 ? bus.m1_addr  : bus.m0_addr;
                    l_wdata <= pick1 ? bus.m1_wdata : bus.m0_wdata;
                    cnt     <= 4'(WAIT_CYCLES);
                    state   <= XFER;
                end
            end else begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state <= IDLE;
                    err_q <= ~in_range;
                    if (win) begin
                        ack1 <= 1'b1;
                        rd1  <= (l_we | ~in_range) ? 32'd0 : bus.dev_rdata;
                    end else begin
                        ack0 <= 1'b1;
                        rd0  <= (l_we | ~in_range) ? 32'd0 : bus.dev_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pr_bus_arbiter.sv
module tb_pr_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // three arbiters with different wait times share the master stimulus
    pr_bus_arbiter_if b0();
    pr_bus_arbiter_if b2();
    pr_bus_arbiter_if b3();

    pr_bus_arbiter #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    pr_bus_arbiter #(.WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
    pr_bus_arbiter #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    assign b0.m0_req = m0_req; assign b0.m0_we = m0_we; assign b0.m0_addr = m0_addr; assign b0.m0_wdata = m0_wdata;
    assign b0.m1_req = m1_req; assign b0.m1_we = m1_we; assign b0.m1_addr = m1_addr; assign b0.m1_wdata = m1_wdata;
    assign b2.m0_req = m0_req; assign b2.m0_we = m0_we; assign b2.m0_addr = m0_addr; assign b2.m0_wdata = m0_wdata;
    assign b2.m1_req = m1_req; assign b2.m1_we = m1_we; assign b2.m1_addr = m1_addr; assign b2.m1_wdata = m1_wdata;
    assign b3.m0_req = m0_req; assign b3.m0_we = m0_we; assign b3.m0_addr = m0_addr; assign b3.m0_wdata = m0_wdata;
    assign b3.m1_req = m1_req; assign b3.m1_we = m1_we; assign b3.m1_addr = m1_addr; assign b3.m1_wdata = m1_wdata;

    // Device model: unwritten locations read a fixed pattern of their index.
    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h20) ? 32'h0000_1234 : {24'hC0DE00, a};
    endfunction

    logic [31:0] mem0 [256];
    logic [31:0] mem2 [256];
    logic [31:0] mem3 [256];
    logic [255:0] wr0 = '0;
    logic [255:0] wr2 = '0;
    logic [255:0] wr3 = '0;

    always @(posedge clk) begin
        if (b0.dev_we) begin mem0[b0.dev_addr[7:0]] <= b0.dev_wdata; wr0[b0.dev_addr[7:0]] <= 1'b1; end
        if (b2.dev_we) begin mem2[b2.dev_addr[7:0]] <= b2.dev_wdata; wr2[b2.dev_addr[7:0]] <= 1'b1; end
        if (b3.dev_we) begin mem3[b3.dev_addr[7:0]] <= b3.dev_wdata; wr3[b3.dev_addr[7:0]] <= 1'b1; end
    end

    assign b0.dev_rdata = wr0[b0.dev_addr[7:0]] ? mem0[b0.dev_addr[7:0]] : init_val(b0.dev_addr[7:0]);
    assign b2.dev_rdata = wr2[b2.dev_addr[7:0]] ? mem2[b2.dev_addr[7:0]] : init_val(b2.dev_addr[7:0]);
    assign b3.dev_rdata = wr3[b3.dev_addr[7:0]] ? mem3[b3.dev_addr[7:0]] : init_val(b3.dev_addr[7:0]);

    // pulse counters on dut0
    int we0_cnt = 0, err0_cnt = 0, ack0_cnt = 0;
    always @(negedge clk) begin
        if (b0.dev_we) we0_cnt  <= we0_cnt + 1;
        if (b0.err)    err0_cnt <= err0_cnt + 1;
        if (b0.m0_ack) ack0_cnt <= ack0_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; m0_req = 0; m1_req = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // one m0 transaction on dut0; lat = negedges from req to ack, -1 on timeout
    task automatic m0_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        m0_we = we; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        lat = -1; rd = '0; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (b0.m0_ack) begin lat = c; rd = b0.m0_rdata; e = b0.err; break; end
        end
        m0_req = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;     // expected rdata at ack
        logic        er;     // expected err
        logic [31:0] wrs;    // expected dev_we pulses
    } vec_t;

    vec_t vt [8];

    initial begin
        int lat, c0, c1, both, last_c, acks;
        int s_we, s_err, s_ack, stable;
        logic [31:0] rd;
        logic e;
        logic [3:0] order;

        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0, 32'd1};
        vt[1] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0, 32'd0};
        vt[2] = '{1'b0, 32'h0000_0024, 32'h0,          32'hC0DE_0024, 1'b0, 32'd0};
        vt[3] = '{1'b1, 32'h0000_8000, 32'h1111_1111, 32'h0,          1'b1, 32'd0};
        vt[4] = '{1'b0, 32'h0000_7FFF, 32'h0,          32'hC0DE_00FF, 1'b0, 32'd0};
        vt[5] = '{1'b0, 32'h0000_8000, 32'h0,          32'h0,          1'b1, 32'd0};
        vt[6] = '{1'b1, 32'h0000_7FFF, 32'h0000_CAFE, 32'h0,          1'b0, 32'd1};
        vt[7] = '{1'b0, 32'h0000_7FFF, 32'h0,          32'h0000_CAFE, 1'b0, 32'd0};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", {30'd0, b0.m0_ack, b0.m1_ack}, 32'd0);
        chk("rst_rdata", b0.m0_rdata | b0.m1_rdata, 32'd0);
        chk("rst_dev", {31'd0, b0.dev_we} | b0.dev_addr | b0.dev_wdata, 32'd0);
        chk("rst_err", {31'd0, b0.err}, 32'd0);
        rst = 1'b1;

        // single m0 transactions, WAIT_CYCLES=0
        for (int i = 0; i < 8; i++) begin
            s_we = we0_cnt; s_err = err0_cnt;
            m0_txn(vt[i].we, vt[i].addr, vt[i].wdata, lat, rd, e);
            @(negedge clk);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d_err_at_ack", i), {31'd0, e}, {31'd0, vt[i].er});
            chk($sformatf("v%0d_err_pulses", i), 32'(err0_cnt - s_err), {31'd0, vt[i].er});
            chk($sformatf("v%0d_dev_we_pulses", i), 32'(we0_cnt - s_we), vt[i].wrs);
        end
        chk("oor_no_write", {31'd0, wr0[0]}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rdata_hold", b0.m0_rdata, 32'h0000_CAFE);

        // simultaneous requests from reset alternate m0, m1, m0, m1
        do_reset();
        m0_we = 0; m0_addr = 32'h40; m1_we = 0; m1_addr = 32'h44;
        m0_req = 1; m1_req = 1;
        order = '0; both = 0; last_c = -1; acks = 0;
        for (int c = 1; c <= 30 && acks < 4; c++) begin
            @(negedge clk);
            if (b0.m0_ack && b0.m1_ack) both++;
            if (b0.m0_ack || b0.m1_ack) begin
                order = {order[2:0], b0.m1_ack};
                acks++;
                last_c = c;
            end
        end
        m0_req = 0; m1_req = 0;
        chk("rr_acks", 32'(acks), 32'd4);
        chk("rr_order", {28'd0, order}, 32'h5);
        chk("rr_both_acks", 32'(both), 32'd0);
        chk("rr_throughput", 32'(last_c), 32'd8);
        chk("rr_m1_rdata", b0.m1_rdata, 32'hC0DE_0044);

        // WAIT_CYCLES=3 read by m1
        do_reset();
        @(negedge clk);
        m1_we = 0; m1_addr = 32'h20; m1_req = 1;
        lat = -1; stable = 0; rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 4 && b3.dev_addr == 32'h20 && !b3.dev_we) stable++;
            if (b3.m1_ack) begin lat = c; rd = b3.m1_rdata; break; end
        end
        m1_req = 0;
        chk("w3_lat", 32'(lat), 32'd5);
        chk("w3_addr_stable", 32'(stable), 32'd4);
        chk("w3_rdata", rd, 32'h0000_1234);

        // async reset during the write cycle of a WAIT_CYCLES=2 write
        do_reset();
        @(negedge clk);
        m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h9999; m0_req = 1;
        repeat (3) @(negedge clk);
        chk("w2_we_before_rst", {31'd0, b2.dev_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("w2_rst_ack_err", {29'd0, b2.m0_ack, b2.m1_ack, b2.err}, 32'd0);
        chk("w2_rst_dev", {31'd0, b2.dev_we} | b2.dev_addr | b2.dev_wdata, 32'd0);
        chk("w2_rst_rdata", b2.m0_rdata | b2.m1_rdata, 32'd0);
        repeat (3) @(negedge clk);
        m0_we = 0; m1_we = 0; m1_addr = 32'h34; m1_req = 1;
        rst = 1'b1;
        c0 = -1; c1 = -1; rd = '0;
        for (int c = 1; c <= 20 && c0 < 0; c++) begin
            @(negedge clk);
            if (b2.m1_ack && c1 < 0) c1 = c;
            if (b2.m0_ack) begin c0 = c; rd = b2.m0_rdata; end
        end
        m0_req = 0; m1_req = 0;
        chk("w2_no_write", {31'd0, wr2[8'h30]}, 32'd0);
        chk("w2_m0_first_lat", 32'(c0), 32'd4);
        chk("w2_m1_not_first", 32'(c1), 32'hFFFF_FFFF);
        chk("w2_rdata", rd, 32'hC0DE_0030);

        // master changes addr/wdata after grant and drops req early
        do_reset();
        @(negedge clk);
        s_we = we0_cnt; s_ack = ack0_cnt;
        m0_we = 1; m0_addr = 32'h50; m0_wdata = 32'hAAAA_5555; m0_req = 1;
        @(negedge clk);
        m0_addr = 32'h54; m0_wdata = 32'h0000_0001; m0_req = 0;
        repeat (6) @(negedge clk);
        chk("late_ack_pulses", 32'(ack0_cnt - s_ack), 32'd1);
        chk("late_we_pulses", 32'(we0_cnt - s_we), 32'd1);
        chk("late_wr_flag", {31'd0, wr0[8'h50]}, 32'd1);
        chk("late_mem", mem0[8'h50], 32'hAAAA_5555);
        chk("late_other_untouched", {31'd0, wr0[8'h54]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pr_bus_arbiter.md
Name: pr_bus_arbiter

Overview:
- Shares the single processor-side device bus (address, write data, write enable, read data) between two masters.
  - m0: the mips core.
  - m1: a secondary master (debug loader / DMA engine).
- Serialises one transaction at a time, with round-robin fairness, a programmable device wait time and an address-range guard.
- Sits between the masters and the memory-mapped device block. Device read data is combinational from the address; device writes commit on the rising clock edge when write enable is high.

Parameters:
- WAIT_CYCLES, 0, extra device-access cycles added before a transaction completes (0..15).
- ADDR_MAX, 32'h0000_7FFF, highest legal device address; addresses above it are rejected.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- m0_req  input  1  master 0 request, held high until ack
- m0_we  input  1  master 0 write (1) / read (0)
- m0_addr  input  32  master 0 address
- m0_wdata  input  32  master 0 write data
- m0_ack  output  1  one-cycle completion pulse to master 0
- m0_rdata  output  32  read data returned to master 0, valid while ack high
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*, for master 1
- dev_we  output  1  device write enable
- dev_addr  output  32  device address
- dev_wdata  output  32  device write data
- dev_rdata  input  32  device read data (combinational from dev_addr)
- err  output  1  one-cycle pulse: completed transaction was out of range

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; round-robin pointer = m0.
  - All outputs 0: ack, rdata, dev_*, err.
  - Any in-flight transaction is aborted; no device write occurs at any edge while rst is low.
- States:
  - IDLE -> XFER on an edge where an eligible req is high.
  - XFER -> IDLE on the final XFER edge.
- Eligibility: a master is not eligible while its own ack is high. The req still visible in the ack cycle is never taken as a new request.
- Arbitration, at the IDLE edge:
  - Exactly one eligible req: that master wins.
  - Both eligible: the pointer's master wins.
  - The pointer is then set to the loser/other master, so it alternates after every granted transaction.
- Grant edge: latch the winner id plus its we, addr and wdata into internal registers; wait counter = WAIT_CYCLES. Master-side changes after this edge are ignored.
- XFER:
  - dev_addr and dev_wdata are driven from the latched registers for the whole state.
  - dev_we = latched_we AND (counter==0) AND in_range, i.e. high only in the final XFER cycle.
  - Each XFER edge with counter>0 decrements the counter.
- Final XFER edge (counter==0):
  - The device commits the write.
  - The winner's rdata register captures dev_rdata for a read, or 0 for a write or out-of-range access.
  - The winner's ack is set to 1 for exactly the next cycle.
  - err is set to 1 for that same cycle if addr > ADDR_MAX.
  - State -> IDLE.
- Latency: req high before edge E0 -> ack high during the cycle after edge E(WAIT_CYCLES+1).
  - WAIT_CYCLES=0: ack in the 2nd cycle after req.
- Back-to-back: an edge in IDLE that coincides with an ack cycle may grant the other master. Max throughput is one transaction per WAIT_CYCLES+2 cycles.
- Outside XFER: dev_we=0; dev_addr/dev_wdata hold their last values.
- req withdrawn:
  - Before grant: nothing happens.
  - After grant: the transaction still completes and ack still pulses.
- Out of range: no device write; rdata=0; err pulses alongside ack.
- rdata holds its value until the next completion for that master.

Test Plan:
1. WAIT_CYCLES=0; m0 write addr=0x10 data=0xDEADBEEF, then read 0x10 -> dev_we high exactly 1 cycle, m0_ack 2 cycles after each req, m0_rdata=0xDEADBEEF.
2. m0 and m1 req on the same edge from reset, both held for 4 transactions -> grant order m0, m1, m0, m1; no cycle with both acks high.
3. WAIT_CYCLES=3; m1 read of 0x20 preloaded with 0x1234 -> m1_ack in the 5th cycle after req, dev_addr=0x20 stable for all 4 XFER cycles, m1_rdata=0x1234.
4. m0 write to 0x8000 (> ADDR_MAX) -> dev_we never high, device location unchanged, err and m0_ack pulse together, m0_rdata=0.
5. Reset asserted asynchronously mid-XFER of a write with WAIT_CYCLES=2 -> all outputs 0 immediately, target location unchanged; after release, m0 wins the first simultaneous request.
6. m0 changes addr/wdata the cycle after grant, then drops req before ack -> device written with the originally latched values, ack still pulses once.
